// File: rtl/rotation_sequencer.sv
// Frame-loop sequencer for the WS2812B strip: alternates pattern generation and
// serial transmission, and advances a rotation offset every FRAMES_PER_STEP frames.
module rotation_sequencer #(
  parameter int NUM_LEDS        = 16,
  parameter int OFFSET_W        = 4,
  parameter int FRAMES_PER_STEP = 4,
  parameter int FRAME_W         = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                mode,
  input  logic                dir,
  input  logic                genDone,
  input  logic                sendDone,
  output logic                genStart,
  output logic                sendStart,
  output logic [OFFSET_W-1:0] offset,
  output logic                wrapPulse,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_WAIT_GEN,
    S_SEND,
    S_WAIT_SEND
  } state_t;

  localparam logic [OFFSET_W-1:0] OFFSET_MAX = OFFSET_W'(NUM_LEDS - 1);
  localparam logic [FRAME_W-1:0]  FRAME_LAST = FRAME_W'(FRAMES_PER_STEP - 1);

  state_t                state;
  state_t                state_next;
  logic [FRAME_W-1:0]    frame_cnt;
  logic                  bounce_down;
  logic                  frame_done;
  logic [OFFSET_W-1:0]   offset_next;
  logic                  wrap_next;
  logic                  down_next;
  logic                  step_down;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      offset      <= '0;
      frame_cnt   <= '0;
      bounce_down <= 1'b0;
      wrapPulse   <= 1'b0;
    end else begin
      state     <= state_next;
      wrapPulse <= 1'b0;
      if (frame_done) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          offset      <= offset_next;
          wrapPulse   <= wrap_next;
          bounce_down <= down_next;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    genStart   = 1'b0;
    sendStart  = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE:      if (enable) state_next = S_GEN;
      S_GEN: begin
        genStart   = 1'b1;
        state_next = S_WAIT_GEN;
      end
      S_WAIT_GEN:  if (genDone) state_next = S_SEND;
      S_SEND: begin
        sendStart  = 1'b1;
        state_next = S_WAIT_SEND;
      end
      S_WAIT_SEND: begin
        if (sendDone) begin
          frame_done = 1'b1;
          state_next = enable ? S_GEN : S_IDLE;
        end
      end
      default:     state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Candidate offset for the next advance; only committed on the last frame of a step.
  always_comb begin
    offset_next = offset;
    wrap_next   = 1'b0;
    down_next   = bounce_down;
    step_down   = 1'b0;
    if (!mode) begin
      if (!dir) begin
        if (offset == OFFSET_MAX) begin
          offset_next = '0;
          wrap_next   = 1'b1;
        end else begin
          offset_next = offset + 1'b1;
        end
      end else begin
        if (offset == '0) begin
          offset_next = OFFSET_MAX;
          wrap_next   = 1'b1;
        end else begin
          offset_next = offset - 1'b1;
        end
      end
    end else begin
      // An end reached while in wrap mode turns the bounce around before stepping.
      step_down = bounce_down;
      if (!bounce_down && offset == OFFSET_MAX) begin
        step_down = 1'b1;
      end else if (bounce_down && offset == '0) begin
        step_down = 1'b0;
      end
      offset_next = step_down ? offset - 1'b1 : offset + 1'b1;
      down_next   = step_down;
      if (!step_down && offset_next == OFFSET_MAX) begin
        down_next = 1'b1;
        wrap_next = 1'b1;
      end else if (step_down && offset_next == '0) begin
        down_next = 1'b0;
        wrap_next = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rotation_sequencer.sv
// Self-checking bench for rotation_sequencer: frame-level vector table, hand-written
// corner sequences and randomized frames against a frame-count based offset model.
module tb_rotation_sequencer;

  localparam int N   = 4;
  localparam int FPS = 2;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       mode;
  logic       dir;
  logic       genDone;
  logic       sendDone;
  logic       genStart;
  logic       sendStart;
  logic [1:0] offset;
  logic       wrapPulse;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int m_off    = 0;
  int m_frames = 0;
  int m_wrap   = 0;
  bit m_down   = 0;

  typedef struct {
    bit rst_before;
    bit md;
    bit dr;
    int exp_off;
    int exp_wrap;
  } vec_t;

  vec_t vecs[$];

  rotation_sequencer #(
    .NUM_LEDS(N),
    .OFFSET_W(2),
    .FRAMES_PER_STEP(FPS),
    .FRAME_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .mode(mode),
    .dir(dir),
    .genDone(genDone),
    .sendDone(sendDone),
    .genStart(genStart),
    .sendStart(sendStart),
    .offset(offset),
    .wrapPulse(wrapPulse),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Offset model: every FPS-th completed frame moves the offset one LED.
  function automatic void model_frame(input bit md, input bit dr);
    int step;
    m_wrap = 0;
    m_frames++;
    if (m_frames % FPS != 0) return;
    if (!md) begin
      if (!dr) begin
        m_wrap = (m_off == N - 1) ? 1 : 0;
        m_off  = (m_off + 1) % N;
      end else begin
        m_wrap = (m_off == 0) ? 1 : 0;
        m_off  = (m_off + N - 1) % N;
      end
    end else begin
      step = m_down ? -1 : 1;
      if (m_off + step < 0 || m_off + step > N - 1) step = -step;
      m_off  = m_off + step;
      m_down = (step < 0);
      if (step > 0 && m_off == N - 1) begin
        m_down = 1;
        m_wrap = 1;
      end else if (step < 0 && m_off == 0) begin
        m_down = 0;
        m_wrap = 1;
      end
    end
  endfunction

  function automatic void model_reset();
    m_off    = 0;
    m_frames = 0;
    m_wrap   = 0;
    m_down   = 0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  // Plays the generator and sender for one frame, checking handshake timing.
  task automatic run_frame(input int gen_lat, input int send_lat, input bit drop_en, input bit spurious);
    int waited;
    waited = 0;
    while (!genStart && waited < 40) begin
      tick();
      waited++;
    end
    checkOutput("gen_start_seen", int'(genStart), 1);
    if (!genStart) return;
    checkOutput("offset_stable_gen", int'(offset), m_off);
    tick();
    if (drop_en) enable = 1'b0;
    checkOutput("gen_start_single", int'(genStart), 0);
    checkOutput("wrap_pulse_single", int'(wrapPulse), 0);
    for (int i = 1; i < gen_lat; i++) begin
      if (spurious && i == 1) sendDone = 1'b1;
      tick();
      sendDone = 1'b0;
    end
    genDone = 1'b1;
    tick();
    genDone = 1'b0;
    checkOutput("send_start_latency", int'(sendStart), 1);
    tick();
    checkOutput("send_start_single", int'(sendStart), 0);
    for (int i = 1; i < send_lat; i++) begin
      if (spurious && i == 1) genDone = 1'b1;
      tick();
      genDone = 1'b0;
    end
    checkOutput("offset_stable_send", int'(offset), m_off);
    sendDone = 1'b1;
    tick();
    sendDone = 1'b0;
    model_frame(mode, dir);
    checkOutput("offset", int'(offset), m_off);
    checkOutput("wrap_pulse", int'(wrapPulse), m_wrap);
    checkOutput("next_gen", int'(genStart), int'(enable));
    checkOutput("busy_after_frame", int'(busy), int'(enable));
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.rst_before) do_reset();
    mode = v.md;
    dir  = v.dr;
    run_frame(3, 10, 1'b0, 1'b0);
    checkOutput("tbl_offset", int'(offset), v.exp_off);
    checkOutput("tbl_wrap", int'(wrapPulse), v.exp_wrap);
  endtask

  initial begin
    bit seen;
    int wrap_tbl[16];
    int off_tbl[16];

    reset    = 1'b1;
    enable   = 1'b0;
    mode     = 1'b0;
    dir      = 1'b0;
    genDone  = 1'b0;
    sendDone = 1'b0;

    // Wrap increment (8 frames), then decrement from 0 (4 frames).
    off_tbl  = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 3, 3, 2, 0, 0, 0, 0};
    wrap_tbl = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++)
      vecs.push_back('{1'b0, 1'b0, (i >= 8), off_tbl[i], wrap_tbl[i]});
    // Bounce from a fresh reset, 8 steps over 16 frames.
    off_tbl  = '{0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0, 0, 1, 1, 2};
    wrap_tbl = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++)
      vecs.push_back('{(i == 0), 1'b1, 1'b0, off_tbl[i], wrap_tbl[i]});

    tick();
    tick();
    checkOutput("reset_offset", int'(offset), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_gen_start", int'(genStart), 0);
    checkOutput("reset_send_start", int'(sendStart), 0);
    checkOutput("reset_wrap", int'(wrapPulse), 0);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 6; i++) begin
      genDone  = (i % 2 == 0);
      sendDone = (i % 2 == 1);
      tick();
      genDone  = 1'b0;
      sendDone = 1'b0;
      checkOutput("idle_gen_start", int'(genStart), 0);
      checkOutput("idle_send_start", int'(sendStart), 0);
      checkOutput("idle_busy", int'(busy), 0);
      checkOutput("idle_offset", int'(offset), 0);
    end

    enable = 1'b1;
    tick();
    checkOutput("enable_latency", int'(genStart), 1);
    checkOutput("enable_busy", int'(busy), 1);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Enable dropped while waiting for the generator.
    mode = 1'b0;
    dir  = 1'b0;
    run_frame(3, 10, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (genStart || busy) seen = 1'b1;
    end
    checkOutput("no_gen_after_drop", int'(seen), 0);

    // Reset while waiting for the sender, with offset at 2.
    enable = 1'b1;
    tick();
    checkOutput("restart_gen", int'(genStart), 1);
    enable = 1'b0;
    tick();
    genDone = 1'b1;
    tick();
    genDone = 1'b0;
    tick();
    checkOutput("offset_before_reset", int'(offset), 2);
    checkOutput("busy_before_reset", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_offset", int'(offset), 0);
    checkOutput("async_reset_busy", int'(busy), 0);
    checkOutput("async_reset_send_start", int'(sendStart), 0);
    tick();
    reset = 1'b0;
    model_reset();
    sendDone = 1'b1;
    tick();
    sendDone = 1'b0;
    checkOutput("late_send_done_busy", int'(busy), 0);
    checkOutput("late_send_done_offset", int'(offset), 0);
    checkOutput("late_send_done_wrap", int'(wrapPulse), 0);
    enable = 1'b1;
    run_frame(2, 3, 1'b0, 1'b0);
    run_frame(2, 3, 1'b0, 1'b0);

    // Randomized frames with mode/dir changes and stray done pulses.
    for (int f = 0; f < 48; f++) begin
      mode = 1'($urandom_range(0, 1));
      dir  = 1'($urandom_range(0, 1));
      run_frame(int'($urandom_range(2, 6)), int'($urandom_range(2, 12)), 1'b0,
                1'($urandom_range(0, 1)));
    end

    enable = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
